// File: rtl/stream_extremum_pkg.sv
// -----------------------------------------------------------------------------
// stream_extremum_pkg
// Shared definitions for the streaming min/max reduction unit:
//   - state_t        : FSM encoding (IDLE / ACCUM / HOLD)
//   - idx_w/bcnt_w   : width derivations for element index and beat counter
//   - extend         : widen a DATA_WIDTH value to CMP_W bits (sign or zero)
//   - better         : strict "a beats b" compare for min or max mode
// No ports (package).
// -----------------------------------------------------------------------------
package stream_extremum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Common compare width; element widths up to 64 bits are supported.
   localparam int CMP_W = 64;

   function automatic int idx_w(input int vec_len);
      return (vec_len > 1) ? $clog2(vec_len) : 1;
   endfunction

   function automatic int bcnt_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

   // Bits at or above 'width' are filled with the element's sign bit when
   // is_signed is set, else with zero, so one wide compare serves both modes.
   function automatic logic [CMP_W-1:0] extend(input logic [CMP_W-1:0] v,
                                               input int               width,
                                               input logic             is_signed);
      logic [CMP_W-1:0] r;
      logic             fill;
      fill = is_signed & v[6'(width - 1)];
      for (int i = 0; i < CMP_W; i++) begin
         r[6'(i)] = (i < width) ? v[6'(i)] : fill;
      end
      return r;
   endfunction

   // Strictly better: equal values never win, which keeps the lowest index.
   function automatic logic better(input logic [CMP_W-1:0] a,
                                   input logic [CMP_W-1:0] b,
                                   input logic             mode_max,
                                   input logic             is_signed);
      logic gt;
      logic lt;
      if (is_signed) begin
         gt = $signed(a) > $signed(b);
         lt = $signed(a) < $signed(b);
      end else begin
         gt = a > b;
         lt = a < b;
      end
      return mode_max ? gt : lt;
   endfunction

endpackage

// File: rtl/stream_extremum_tree.sv
// -----------------------------------------------------------------------------
// stream_extremum_tree
// Combinational log2(LANES)-level comparator tree over one input beat.
// Ports:
//   i_data     : LANES elements, lane k at [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
//   i_mode_max : 0 = pick minimum, 1 = pick maximum
//   o_value    : winning element value
//   o_lane     : lane index of the winner (lowest lane wins ties)
// -----------------------------------------------------------------------------
module stream_extremum_tree
   import stream_extremum_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int LANES      = 4,
   parameter  int SIGNED     = 1,
   localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic [DATA_WIDTH*LANES-1:0] i_data,
   input  logic                        i_mode_max,
   output logic [DATA_WIDTH-1:0]       o_value,
   output logic [LANE_W-1:0]           o_lane
);

   localparam int   LEVELS    = $clog2(LANES);
   localparam logic IS_SIGNED = (SIGNED != 0);

   always_comb begin
      logic [DATA_WIDTH-1:0] val [LEVELS+1][LANES];
      logic [LANE_W-1:0]     idx [LEVELS+1][LANES];
      for (int l = 0; l <= LEVELS; l++) begin
         for (int n = 0; n < LANES; n++) begin
            val[l][n] = '0;
            idx[l][n] = '0;
         end
      end
      for (int k = 0; k < LANES; k++) begin
         val[0][k] = i_data[DATA_WIDTH*k +: DATA_WIDTH];
         idx[0][k] = LANE_W'(k);
      end
      // The left child always covers lower lanes than the right child, so
      // taking the right one only when strictly better keeps the lowest lane.
      for (int l = 0; l < LEVELS; l++) begin
         for (int n = 0; n < (LANES >> (l + 1)); n++) begin
            if (better(extend(CMP_W'(val[l][2*n+1]), DATA_WIDTH, IS_SIGNED),
                       extend(CMP_W'(val[l][2*n]),   DATA_WIDTH, IS_SIGNED),
                       i_mode_max, IS_SIGNED)) begin
               val[l+1][n] = val[l][2*n+1];
               idx[l+1][n] = idx[l][2*n+1];
            end else begin
               val[l+1][n] = val[l][2*n];
               idx[l+1][n] = idx[l][2*n];
            end
         end
      end
      o_value = val[LEVELS][0];
      o_lane  = idx[LEVELS][0];
   end

endmodule

// File: rtl/stream_extremum.sv
// -----------------------------------------------------------------------------
// stream_extremum
// Streaming min/max reduction: one vector of VEC_LEN elements arrives as
// LANES-wide beats; the unit returns the extreme value and its element index.
// Handshakes: a beat transfers when i_in_valid & o_in_ready are high at a
// rising edge; a result transfers when o_out_valid & i_out_ready are high at a
// rising edge. Both ready/valid outputs are registered, so nothing on the
// input side combinationally reaches o_in_ready.
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   i_mode_max    : 0 = min, 1 = max, taken from the first beat of a vector
//   i_in_valid/o_in_ready/i_in_data/i_in_last : beat stream
//   o_out_valid/i_out_ready : result handshake
//   o_out_value   : extreme value
//   o_out_index   : element index (beat*LANES + lane)
//   o_out_len_err : vector did not contain exactly BEATS beats
//   o_state       : current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module stream_extremum
   import stream_extremum_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int LANES      = 4,
   parameter  int VEC_LEN    = 64,
   parameter  int SIGNED     = 1,
   localparam int BEATS      = VEC_LEN / LANES,
   localparam int IDX_W      = idx_w(VEC_LEN),
   localparam int BCNT_W     = bcnt_w(BEATS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_mode_max,
   input  logic                        i_in_valid,
   output logic                        o_in_ready,
   input  logic [DATA_WIDTH*LANES-1:0] i_in_data,
   input  logic                        i_in_last,
   output logic                        o_out_valid,
   input  logic                        i_out_ready,
   output logic [DATA_WIDTH-1:0]       o_out_value,
   output logic [IDX_W-1:0]            o_out_index,
   output logic                        o_out_len_err,
   output logic [1:0]                  o_state
);

   localparam int   LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic IS_SIGNED = (SIGNED != 0);

   state_t                r_state;
   logic                  r_mode_max;
   logic [BCNT_W-1:0]     r_beat_cnt;
   logic [DATA_WIDTH-1:0] r_acc_val;
   logic [IDX_W-1:0]      r_acc_idx;
   logic                  r_len_err;
   logic                  r_in_ready;
   logic                  r_out_valid;

   logic                  w_mode;
   logic [DATA_WIDTH-1:0] w_tree_val;
   logic [LANE_W-1:0]     w_tree_lane;
   logic [IDX_W-1:0]      w_elem_idx;
   logic                  w_accept;
   logic                  w_cnt_last;
   logic                  w_term;
   logic                  w_len_err;
   logic                  w_take;

   // The first beat of a vector uses the live mode; later beats use the latch.
   assign w_mode = (r_state == ST_IDLE) ? i_mode_max : r_mode_max;

   stream_extremum_tree #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .SIGNED     (SIGNED)
   ) u_tree (
      .i_data     (i_in_data),
      .i_mode_max (w_mode),
      .o_value    (w_tree_val),
      .o_lane     (w_tree_lane)
   );

   // r_in_ready is only ever high in IDLE/ACCUM, so accept implies one of them.
   assign w_accept   = i_in_valid & r_in_ready;
   // r_beat_cnt is zero in IDLE, so the same base works for the first beat.
   assign w_elem_idx = IDX_W'(int'(r_beat_cnt) * LANES + int'(w_tree_lane));
   // Beat being accepted is the BEATS-th one (also true in IDLE when BEATS==1).
   assign w_cnt_last = (r_beat_cnt == BCNT_W'(BEATS - 1));
   assign w_term     = i_in_last | w_cnt_last;
   // Clean only when in_last lands exactly on the BEATS-th beat.
   assign w_len_err  = ~(i_in_last & w_cnt_last);
   assign w_take     = (r_state == ST_IDLE) |
                       better(extend(CMP_W'(w_tree_val), DATA_WIDTH, IS_SIGNED),
                              extend(CMP_W'(r_acc_val),  DATA_WIDTH, IS_SIGNED),
                              r_mode_max, IS_SIGNED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_mode_max  <= 1'b0;
         r_beat_cnt  <= '0;
         r_acc_val   <= '0;
         r_acc_idx   <= '0;
         r_len_err   <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_ACCUM: begin
               if (r_state == ST_IDLE) begin
                  r_in_ready <= 1'b1;
               end
               if (w_accept) begin
                  if (r_state == ST_IDLE) begin
                     r_mode_max <= i_mode_max;
                  end
                  if (w_take) begin
                     r_acc_val <= w_tree_val;
                     r_acc_idx <= w_elem_idx;
                  end
                  if (w_term) begin
                     r_state     <= ST_HOLD;
                     r_beat_cnt  <= '0;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_len_err   <= w_len_err;
                  end else begin
                     r_state    <= ST_ACCUM;
                     r_beat_cnt <= r_beat_cnt + BCNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (i_out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // The accumulator doubles as the result register; it cannot change in
   // HOLD because no beat is accepted there.
   assign o_in_ready    = r_in_ready;
   assign o_out_valid   = r_out_valid;
   assign o_out_value   = r_acc_val;
   assign o_out_index   = r_acc_idx;
   assign o_out_len_err = r_len_err;
   assign o_state       = r_state;

endmodule

// File: doc/stream_extremum.md
# stream_extremum

Streaming min/max reduction unit for the attention datapath: it accepts one vector of VEC_LEN elements as a sequence of LANES-wide beats and returns the extreme value and its element index. It is the sequential, handshaked successor of the combinational single-shot minimum block. Typical uses are row-max before softmax and min-search for ranking.

## Interface
- DATA_WIDTH, 16, element width in bits
- LANES, 4, elements per input beat; power of two, ≥1
- VEC_LEN, 64, elements per vector; multiple of LANES, ≥2
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare
- Derived: BEATS = VEC_LEN/LANES; IDX_W = $clog2(VEC_LEN); BCNT_W = max(1, $clog2(BEATS))
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- mode_max  input  1  0 = minimum, 1 = maximum; sampled on the first accepted beat of a vector
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid & in_ready at a rising edge
- in_data  input  DATA_WIDTH*LANES  lane k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
- in_last  input  1  final beat of the vector
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid & out_ready at a rising edge
- out_value  output  DATA_WIDTH  extreme value
- out_index  output  IDX_W  element index of out_value, beat*LANES + lane
- out_len_err  output  1  vector length was not BEATS beats

## Operation
- States: IDLE (no beat accepted yet), ACCUM (collecting beats), HOLD (result pending).
- IDLE: on an accepted beat, latch mode_max, load the accumulator from the lane-reduced beat, set beat_cnt = 1, and go to ACCUM. If in_last is also set, go directly to HOLD.
- ACCUM: on each accepted beat, compare the lane winner with the accumulator and keep the better one. Increment beat_cnt.
- Termination: the vector ends on an accepted beat with in_last. It also ends on the BEATS-th accepted beat when in_last is absent (forced end).
- out_len_err = 1 if termination came from in_last with beat count ≠ BEATS, or from forced end. Otherwise 0.
- After a forced end, the next beat starts a new vector. Any later in_last applies to that new vector.
- HOLD: in_ready = 0. On out_valid & out_ready, go to IDLE.
- Ties: the lowest element index wins, both within a beat and across beats. A new beat replaces the accumulator only on strictly better.
- Compare: signed or unsigned per SIGNED. The value is passed through unmodified with no width growth.
- mode_max changes mid-vector are ignored.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, in_ready = 0, out_valid = 0, out_value = 0, out_index = 0, out_len_err = 0, beat_cnt = 0.
- in_ready and out_valid are registered. in_ready rises on the first rising edge after rst_n deasserts.
- Throughput: one beat per cycle in IDLE/ACCUM. No combinational path from out_ready or in_valid to in_ready.
- Latency: on the edge that accepts the terminating beat, out_valid goes to 1 and in_ready goes to 0.
- On the edge where out_valid & out_ready: out_valid goes to 0 and in_ready goes to 1. Minimum gap between vectors is 1 idle cycle.
- out_value, out_index and out_len_err are stable while out_valid = 1 and out_ready = 0.
- Reset asserted mid-vector or mid-HOLD discards the partial or pending result with no output.

## Structure
- Shared package holds the state encoding (IDLE/ACCUM/HOLD), the IDX_W/BCNT_W derivation functions, and a compare function better(a, b, mode_max, signed).
- One sub-module, extremum_tree: a combinational log2(LANES)-level comparator tree over one beat. It outputs the winner value and lane index with the lowest-index tie rule and is parametrised by DATA_WIDTH, LANES and SIGNED.
- The top level holds the FSM, beat counter, accumulator, and the output and handshake registers.

## Test plan
- Defaults, mode_max = 0, 16 beats with element i = 1000 − i, last on beat 15 -> out_value = 937, out_index = 63, out_len_err = 0. Result appears 1 cycle after the last beat.
- SIGNED = 1, mode_max = 1, all elements 16'h8000 except index 37 = 16'hFFFF -> out_value = 16'hFFFF (−1), out_index = 37. With SIGNED = 0: out_value = 16'hFFFF, out_index = 37. With SIGNED = 0 and mode_max = 0: out_value = 16'h8000, out_index = 0.
- Ties: all elements = 5, mode_max = 1 -> out_index = 0. Elements 9 and 12 both = 2 and the rest = 7, mode_max = 0 -> out_index = 9.
- Length errors: in_last on beat 3 -> out_len_err = 1 with result over 12 elements. No in_last for 16 beats -> forced end and out_len_err = 1. The 17th beat starts a new vector.
- Backpressure: hold out_ready = 0 for 5 cycles -> out_* stable and in_ready = 0 throughout. Toggle in_valid randomly -> result identical to the gap-free run.
- Assert rst_n = 0 after 7 beats -> all outputs take reset values. A fresh 16-beat vector afterwards gives the correct result with out_len_err = 0.
